// File: rtl/dealer_pkg.sv
// dealer_pkg: shared types and constants for the card dealer slice.
//   card_t      4-bit card code, 0 = empty slot, 1..13 = A..K
//   P1..P3      player slot indices 0..2
//   B1..B3      banker slot indices 3..5
//   state_t     dealer FSM states
package dealer_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_EMPTY = 4'd0;
  localparam card_t RANK_MIN   = 4'd1;
  localparam card_t RANK_MAX   = 4'd13;

  localparam logic [2:0] P1 = 3'd0;
  localparam logic [2:0] P2 = 3'd1;
  localparam logic [2:0] P3 = 3'd2;
  localparam logic [2:0] B1 = 3'd3;
  localparam logic [2:0] B2 = 3'd4;
  localparam logic [2:0] B3 = 3'd5;

  typedef enum logic {IDLE, HOLD} state_t;

endpackage

// File: rtl/rank_source.sv
// rank_source: free-running card rank generator, always yields 1..13.
//   clock   in   fast clock, rising edge
//   resetb  in   asynchronous active-low reset
//   rank    out  current rank (card_t)
// Build option DEALER_LFSR_EN: when defined the rank comes from an 8-bit
// Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) folded into 1..13; otherwise a
// counter stepping 1,2,...,13,1,...
module rank_source
  import dealer_pkg::*;
(
  input  logic  clock,
  input  logic  resetb,
  output card_t rank
);

`ifdef DEALER_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Shift left, feedback from taps 8,6,5,4 (bits 7,5,4,3).
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) lfsr_q <= 8'hA5;
    else         lfsr_q <= lfsr_d;
  end

  // Fold the LFSR state into the legal rank range.
  assign rank = card_t'((lfsr_q % 8'd13) + 8'd1);
`else
  card_t rank_q, rank_d;

  always_comb begin
    rank_d = (rank_q == RANK_MAX) ? RANK_MIN : rank_q + 4'd1;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) rank_q <= RANK_MIN;
    else         rank_q <= rank_d;
  end

  assign rank = rank_q;
`endif

endmodule

// File: rtl/card_dealer.sv
// card_dealer: latches the free-running rank into one of six hand slots on a
// deal request and drives the per-card outputs for the 7-segment decoders.
//   clock, resetb        fast clock / asynchronous active-low reset
//   deal, slot[2:0]      deal request and target slot (0-2 player, 3-5 banker)
//   clear_hand           synchronous clear of the whole hand, top priority
//   busy                 high while holding off after a capture
//   done / err           one-cycle pulses: card written / deal rejected
//   pcard1..3, dcard1..3 slot contents, 0 = empty
//   slot_valid[5:0]      bit i set when slot i holds a card
// Build option DEALER_LFSR_EN selects the LFSR rank source (see rank_source).
module card_dealer
  import dealer_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int NUM_SLOTS   = 6
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic                 deal,
  input  logic [2:0]           slot,
  input  logic                 clear_hand,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [3:0]           pcard1,
  output logic [3:0]           pcard2,
  output logic [3:0]           pcard3,
  output logic [3:0]           dcard1,
  output logic [3:0]           dcard2,
  output logic [3:0]           dcard3,
  output logic [NUM_SLOTS-1:0] slot_valid
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  card_t                rank;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [NUM_SLOTS-1:0] wr_en;
  logic                 slot_free;
  card_t                card_q [NUM_SLOTS];
  card_t                card_d [NUM_SLOTS];

  rank_source u_rank_source (
    .clock  (clock),
    .resetb (resetb),
    .rank   (rank)
  );

  // Range test first so out-of-range slots never index valid_q.
  assign slot_free = (int'(slot) < NUM_SLOTS) && !valid_q[slot];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = '0;
    if (clear_hand) begin
      // Any simultaneous deal is dropped silently.
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (deal) begin
            if (slot_free) begin
              wr_en   = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << slot;
              valid_d = valid_q | wr_en;
              done_d  = 1'b1;
              state_d = HOLD;
              cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            end else begin
              err_d = 1'b1;
            end
          end
        end
        HOLD: begin
          // Deals are ignored here; leave after HOLD_CYCLES cycles.
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      always_comb begin
        card_d[gi] = card_q[gi];
        if (clear_hand)     card_d[gi] = CARD_EMPTY;
        else if (wr_en[gi]) card_d[gi] = rank;
      end

      always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) card_q[gi] <= CARD_EMPTY;
        else         card_q[gi] <= card_d[gi];
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign slot_valid = valid_q;
  assign pcard1     = card_q[P1];
  assign pcard2     = card_q[P2];
  assign pcard3     = card_q[P3];
  assign dcard1     = card_q[B1];
  assign dcard2     = card_q[B2];
  assign dcard3     = card_q[B3];

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed self-checking bench for card_dealer.
// With DEALER_LFSR_EN defined, captured cards are checked for range 1..13
// only, and a long randomised deal/clear run is added.
module tb_card_dealer;

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic       deal = 1'b0;
  logic [2:0] slot = 3'd0;
  logic       clear_hand = 1'b0;
  logic       busy, done, err;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [5:0] slot_valid;

  int n_vec  = 0;
  int n_miss = 0;
  int m_rank;

  card_dealer #(.HOLD_CYCLES(4), .NUM_SLOTS(6)) dut (
    .clock      (clock),
    .resetb     (resetb),
    .deal       (deal),
    .slot       (slot),
    .clear_hand (clear_hand),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .slot_valid (slot_valid)
  );

  always #5 clock = ~clock;

  // Reference model of the counting rank source.
  always @(posedge clock or negedge resetb) begin
    if (!resetb) m_rank <= 1;
    else         m_rank <= (m_rank == 13) ? 1 : m_rank + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_card(input string tag, input logic [3:0] obs, input logic [3:0] exp);
`ifdef DEALER_LFSR_EN
    check(tag, 32'(obs >= 4'd1 && obs <= 4'd13), 32'd1);
`else
    check(tag, 32'(obs), 32'(exp));
`endif
  endtask

  function automatic logic [3:0] card_of(input int s);
    case (s)
      0: return pcard1;
      1: return pcard2;
      2: return pcard3;
      3: return dcard1;
      4: return dcard2;
      default: return dcard3;
    endcase
  endfunction

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Drive one deal for a single edge; exp = rank the counter shows at that edge.
  task automatic deal_slot(input int s, output logic [3:0] exp);
    slot = 3'(s);
    deal = 1'b1;
    exp  = 4'(m_rank);
    tick();
    deal = 1'b0;
    $display("deal slot %0d: card %0d done %0b err %0b busy %0b valid %b",
             s, card_of(s), done, err, busy, slot_valid);
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  logic [3:0]  e;
  logic [3:0]  p1_saved;
  logic [13:0] seen;

  initial begin
    // Reset state
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_valid", 32'(slot_valid), 0);
    check("rst_cards", 32'({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}), 0);
    @(negedge clock);
    resetb = 1'b1;

    // Deal slot 0 on cycle 5 -> rank 6, busy for 4 cycles
    repeat (5) tick();
    deal_slot(0, e);
    check_card("p1_first", pcard1, 4'd6);
    check("p1_valid", 32'(slot_valid), 32'b000001);
    check("p1_done", 32'(done), 1);
    check("p1_err", 32'(err), 0);
    p1_saved = pcard1;
    // Deal slot 3 while busy: ignored, no err
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        slot = 3'd3;
        deal = 1'b1;
      end
      tick();
      deal = 1'b0;
      check("hold_busy", 32'(busy), (i < 3) ? 32'd1 : 32'd0);
      check("hold_done", 32'(done), 0);
      check("hold_err", 32'(err), 0);
    end
    check("hold_nowrite", 32'(slot_valid), 32'b000001);
    check("hold_d1", 32'(dcard1), 0);

    // Same request in IDLE is accepted
    deal_slot(3, e);
    check_card("d1_card", dcard1, e);
    check("d1_valid", 32'(slot_valid), 32'b001001);
    check("d1_done", 32'(done), 1);
    tick();
    check("d1_done_pulse", 32'(done), 0);
    wait_idle();

    // Rejections: filled slot, out-of-range slot
    deal_slot(0, e);
    check("rej0_err", 32'(err), 1);
    check("rej0_done", 32'(done), 0);
    check("rej0_p1", 32'(pcard1), 32'(p1_saved));
    check("rej0_busy", 32'(busy), 0);
    tick();
    check("rej0_err_pulse", 32'(err), 0);
    deal_slot(6, e);
    check("rej6_err", 32'(err), 1);
    check("rej6_valid", 32'(slot_valid), 32'b001001);
    deal_slot(7, e);
    check("rej7_err", 32'(err), 1);
    tick();

    // Fill remaining slots
    for (int s = 1; s < 6; s++) begin
      if (s == 3) continue;
      deal_slot(s, e);
      check_card("fill_card", card_of(s), e);
      check("fill_done", 32'(done), 1);
      check("fill_overlap", 32'(done & err), 0);
      wait_idle();
    end
    check("full_valid", 32'(slot_valid), 32'h3F);

    // clear_hand with deal slot 2 (already full): no err, no done
    clear_hand = 1'b1;
    slot = 3'd2;
    deal = 1'b1;
    tick();
    clear_hand = 1'b0;
    deal = 1'b0;
    $display("clear: valid %b done %0b err %0b busy %0b", slot_valid, done, err, busy);
    check("clr_cards", 32'({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}), 0);
    check("clr_valid", 32'(slot_valid), 0);
    check("clr_done", 32'(done), 0);
    check("clr_err", 32'(err), 0);
    check("clr_busy", 32'(busy), 0);

    // clear_hand with deal to an empty slot: deal dropped
    clear_hand = 1'b1;
    slot = 3'd0;
    deal = 1'b1;
    tick();
    clear_hand = 1'b0;
    deal = 1'b0;
    check("clr2_valid", 32'(slot_valid), 0);
    check("clr2_done", 32'(done), 0);
    check("clr2_busy", 32'(busy), 0);

    // Asynchronous reset mid-hold
    deal_slot(4, e);
    check("arst_pre_busy", 32'(busy), 1);
    #2 resetb = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_valid", 32'(slot_valid), 0);
    check("arst_d2", 32'(dcard2), 0);
    @(negedge clock);
    resetb = 1'b1;
    deal_slot(0, e);
    check_card("arst_first", pcard1, 4'd1);
    check("arst_first_done", 32'(done), 1);
    check("arst_first_valid", 32'(slot_valid), 32'b000001);
    wait_idle();

`ifdef DEALER_LFSR_EN
    seen = '0;
    clear_hand = 1'b1;
    tick();
    clear_hand = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      int s;
      s = i % 6;
      if (s == 0 && i > 0) begin
        clear_hand = 1'b1;
        tick();
        clear_hand = 1'b0;
        check("lfsr_clr", 32'(slot_valid), 0);
      end
      repeat ($urandom_range(0, 3)) tick();
      deal_slot(s, e);
      check_card("lfsr_card", card_of(s), e);
      check("lfsr_done", 32'(done), 1);
      check("lfsr_overlap", 32'(done & err), 0);
      seen[card_of(s)] = 1'b1;
      wait_idle();
    end
    check("lfsr_all_ranks", 32'(seen), 32'h3FFE);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Card-generation and hand-storage stage directly upstream of the per-card 7-segment decoders.
- A free-running rank source cycles through 1..13 on the fast clock.
- On a deal request, the block latches the current rank into one of six hand slots (player 1-3, banker 1-3).
- Each slot drives one 4-bit card output; value 0 means an empty slot, which the decoder shows as blank.

Parameters:
- HOLD_CYCLES, 4, cycles `busy` stays high after a capture before the next deal is accepted (min 1).
- NUM_SLOTS, 6, number of hand slots; fixed at 6 for this game.

Ports:
- clock  in  1  fast clock; all state on rising edge
- resetb  in  1  asynchronous active-low reset
- deal  in  1  deal request, sampled each cycle
- slot  in  3  target slot with `deal`: 0-2 player card 1-3, 3-5 banker card 1-3
- clear_hand  in  1  synchronous clear of all slots
- busy  out  1  high while not in IDLE; deal ignored while high
- done  out  1  one-cycle pulse when a card is written
- err  out  1  one-cycle pulse on a rejected deal
- pcard1, pcard2, pcard3  out  4 each  player cards; 0 = empty, 1..13 = A..K
- dcard1, dcard2, dcard3  out  4 each  banker cards; same encoding
- slot_valid  out  6  bit i high when slot i holds a card

Behaviour:
- Reset (resetb low, asynchronous):
  - all card outputs 0, slot_valid 0, busy/done/err 0
  - FSM in IDLE, rank 1, hold counter 0
  - takes effect mid-capture or mid-hold; no partial write survives.
- Rank source:
  - 4-bit register; reset 1; +1 every cycle; 13 -> 1 wrap.
  - Values 0 and 14-15 never appear.
- FSM states IDLE, HOLD.
- IDLE with deal=1 and clear_hand=0:
  - Accepted if slot <= 5 and slot_valid[slot]=0:
    - the rank value present in that same cycle is written to the slot at the clock edge
    - slot_valid[slot] set; done pulses the following cycle (registered)
    - FSM -> HOLD, hold counter loads HOLD_CYCLES-1.
  - Rejected if slot > 5 or the slot is already valid:
    - err pulses for one cycle; no write; FSM stays IDLE.
- Latency: card output and slot_valid update one cycle after the accepting edge, aligned with done.
- HOLD:
  - busy=1; deal is ignored with no err and no queueing.
  - Counter decrements; at 0 -> IDLE.
  - busy is high for exactly HOLD_CYCLES cycles after the capture edge.
- busy is registered and equals (state != IDLE).
- clear_hand:
  - highest priority in any state.
  - Next edge: all cards 0, slot_valid 0, FSM -> IDLE, hold counter 0.
  - A simultaneous deal is dropped, with no err and no done.
  - The rank source is not affected.
- Slots are written only via deal; slot order is not enforced here (sequencing is the controller's job).
- done and err are never high in the same cycle.

Optional Feature:
- Macro DEALER_LFSR_EN.
- Defined:
  - rank source is an 8-bit Fibonacci LFSR, taps 8,6,5,4, reset seed 8'hA5, shifted every cycle
  - rank = (lfsr mod 13) + 1, combinational, so still 1..13
  - capture timing and all other behaviour unchanged.
- Undefined: wrapping counter as above.
- A bench must check only the range 1..13 when the macro is defined.

Decomposition:
- Shared package dealer_pkg:
  - card_t (logic [3:0])
  - constants CARD_EMPTY=0, RANK_MIN=1, RANK_MAX=13
  - slot index constants P1..P3=0..2, B1..B3=3..5
  - state enum {IDLE, HOLD}
- One sub-module, rank_source (clock, resetb, rank):
  - holds the counter/LFSR and the DEALER_LFSR_EN selection
  - card_dealer instantiates it once.

Test Plan:
- Reset then run free: rank sequence from first edge is 1,2,...,13,1,2. With HOLD_CYCLES=4, after release deal slot 0 on cycle 5 (rank=6) -> pcard1=6, slot_valid=6'b000001, done one pulse, busy high 4 cycles.
- Deal slot 3 while busy=1 -> no write, no err; same request in IDLE -> dcard1 = current rank, done pulse.
- Deal slot 0 again after it is filled -> err pulse, pcard1 unchanged. Deal slot 6 -> err pulse, no slot_valid change.
- Fill all six slots, then assert clear_hand together with deal slot 2 -> all cards 0, slot_valid 0, no done, no err, busy 0 next cycle.
- Drop resetb asynchronously during HOLD (between edges) -> outputs 0 immediately, busy 0. After release, rank restarts at 1 and the first deal is accepted.
- With DEALER_LFSR_EN defined: 1000 deals with clears in between -> every captured value in 1..13, all 13 values observed, no done/err overlap.
